// File: rtl/memory_access_controller.sv
// Single-transaction byte/halfword access sequencer between a core request port and a
// synchronous memory_unit whose read data follows the address latched on the previous edge.
`timescale 1ns/1ps
module memory_access_controller (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        mem_ctrl,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic MEMORY_READ  = 1'b0;
  localparam logic MEMORY_WRITE = 1'b1;

  typedef enum logic [2:0] {StIdle, StAddr0, StAddr1, StCapt, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        wide_q, wide_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [15:0] rdata_q, rdata_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    wide_d      = wide_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          write_d    = req_write;
          wide_d     = req_wide;
          mem_addr_d = req_addr;
          if (req_write) mem_wdata_d = req_wdata[7:0];
          state_d    = StAddr0;
        end
      end
      StAddr0: begin
        if (wide_q) begin
          // 8-bit add wraps 0xFF to 0x00 for the high byte.
          mem_addr_d = addr_q + 8'd1;
          if (write_q) mem_wdata_d = wdata_q[15:8];
          state_d = StAddr1;
        end else begin
          state_d = write_q ? StResp : StCapt;
        end
      end
      StAddr1: begin
        if (!write_q) rdata_d[7:0] = mem_rdata;
        state_d = write_q ? StResp : StCapt;
      end
      StCapt: begin
        if (wide_q) rdata_d[15:8] = mem_rdata;
        else        rdata_d = {8'h00, mem_rdata};
        state_d = StResp;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      addr_q      <= 8'h00;
      wdata_q     <= 16'h0000;
      write_q     <= 1'b0;
      wide_q      <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      rdata_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      wide_q      <= wide_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Decoded from the state register so an asynchronous reset drops a pending write at once.
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    mem_ctrl  = (write_q && (state_q == StAddr0 || state_q == StAddr1)) ? MEMORY_WRITE
                                                                        : MEMORY_READ;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/memory_access_controller.md
MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Port CLOCK  input  1  single clock, all state updates on its rising edge.
REQ-002 Port RESET  input  1  asynchronous, active-low reset.
REQ-003 Port req_valid  input  1  core presents a request.
REQ-004 Port req_ready  output  1  controller accepts a request this cycle.
REQ-005 Port req_write  input  1  1 = write, 0 = read.
REQ-006 Port req_wide  input  1  1 = two-byte access, 0 = one byte.
REQ-007 Port req_addr  input  DEFAULT_TYPE (8)  byte address of the low byte.
REQ-008 Port req_wdata  input  16  write data; [7:0] to addr, [15:8] to addr+1.
REQ-009 Port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 Port rsp_rdata  output  16  read result; [15:8] = 0 for narrow reads.
REQ-011 Port mem_ctrl  output  MEMORY_FLAG_TYPE  to memory_unit ctrl_bus.
REQ-012 Port mem_addr  output  DEFAULT_TYPE  to memory_unit addr_bus.
REQ-013 Port mem_wdata  output  DEFAULT_TYPE  to memory_unit write_bus.
REQ-014 Port mem_rdata  input  DEFAULT_TYPE  from memory_unit read_bus; reflects the address latched at the previous rising edge.

Function
REQ-015 The controller SHALL implement states IDLE, ADDR0, ADDR1, CAPT, RESP, with all outputs driven from registered state and registered request fields.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid=1 and req_ready=1, capturing addr, wdata, write and wide, and moving to ADDR0.
REQ-017 In ADDR0 mem_addr SHALL equal the captured addr; for writes, mem_ctrl=MEMORY_WRITE and mem_wdata=wdata[7:0].
REQ-018 In ADDR1 mem_addr SHALL equal addr+1 modulo 256 (0xFF wraps to 0x00); for writes, mem_ctrl=MEMORY_WRITE and mem_wdata=wdata[15:8].
REQ-019 mem_ctrl SHALL be MEMORY_READ in every state other than ADDR0/ADDR1 of a write; mem_addr and mem_wdata hold their last value outside ADDR0/ADDR1.
REQ-020 Transitions: ADDR0 -> ADDR1 if wide; ADDR0 -> CAPT if narrow read; ADDR0 -> RESP if narrow write; ADDR1 -> CAPT if read; ADDR1 -> RESP if write; CAPT -> RESP; RESP -> IDLE.
REQ-021 For a wide read, the state SHALL capture mem_rdata into rsp_rdata[7:0] at the end of ADDR1 and into rsp_rdata[15:8] at the end of CAPT.
REQ-022 For a narrow read, the state SHALL capture mem_rdata into rsp_rdata[7:0] and 0x00 into rsp_rdata[15:8] at the end of CAPT.
REQ-023 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata SHALL hold its value until the next read capture, unchanged by writes.
REQ-024 Latency from accept edge to rsp_valid high: narrow write 2 cycles, wide write 3, narrow read 3, wide read 4.
REQ-025 req_valid, req_addr and other request inputs SHALL be ignored outside IDLE; no queueing, at most one transaction in flight.
REQ-026 A read issued after a completed write to the same address SHALL return the written data.

Reset
REQ-027 On RESET=0, the block SHALL enter IDLE asynchronously with req_ready=1, rsp_valid=0, rsp_rdata=0x0000, mem_ctrl=MEMORY_READ, mem_addr=0x00, mem_wdata=0x00, and captured request fields cleared.
REQ-028 Reset asserted during ADDR0/ADDR1 of a write SHALL force mem_ctrl to MEMORY_READ before the next edge; that byte is not written and no rsp_valid is produced.
REQ-029 The first request SHALL be accepted on the first rising edge after RESET returns to 1 with req_valid=1.

Verification
REQ-030 Memory byte 0x10=0xAB, narrow read addr 0x10 -> rsp_valid 3 cycles after accept, rsp_rdata=0x00AB.
REQ-031 Wide write 0x1234 to addr 0xFF, then wide read addr 0xFF -> memory[0xFF]=0x34, memory[0x00]=0x12, read returns 0x1234, write latency 3 cycles, read latency 4 cycles.
REQ-032 req_valid held at 1 throughout with back-to-back narrow writes -> req_ready=0 during ADDR0/RESP, each request accepted once, exactly one rsp_valid pulse per request.
REQ-033 Reset asserted in ADDR1 of a wide write 0xBEEF to 0x20 -> memory[0x20]=0xEF, memory[0x21] unchanged, outputs at reset values immediately, no rsp_valid.
REQ-034 Wide read after a narrow read that returned 0x00AB, followed by a narrow write -> rsp_rdata unchanged from the wide-read result during and after the write's RESP.
